// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int ADDR_W      = 64;
  localparam int INSTR_W     = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

  // A fetch is bad when the address is not word aligned or the last byte of
  // the word lies outside the ROM. The sum is taken one bit wider so that a
  // PC near 2^64 cannot wrap into range.
  function automatic logic fetch_is_bad(input logic [ADDR_W-1:0] pc,
                                        input logic [ADDR_W:0]   mem_size);
    logic [ADDR_W:0] last_byte;
    last_byte = {1'b0, pc} + (ADDR_W+1)'(INSTR_BYTES - 1);
    return (pc[1:0] != 2'b00) || (last_byte >= mem_size);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and the ROM (slave).
interface instr_fetch_unit_if;
  import fetch_pkg::*;

  logic [ADDR_W-1:0]  imem_address;
  logic [INSTR_W-1:0] imem_instruction;

  modport master (output imem_address, input imem_instruction);
  modport slave  (input imem_address, output imem_instruction);

endinterface

// File: rtl/instr_fetch_unit_ifid_reg.sv
// IF/ID pipeline register: captures a fetched word, holds it, or squashes it.
module ifid_reg
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load_i,
  input  logic               squash_i,
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic               valid_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [INSTR_W-1:0] instr_o
);

  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;

  // Squash only drops valid so the data fields never take a wrong-path value.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (squash_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      pc_d    = pc_i;
      instr_d = instr_i;
    end
  end

  // Register state; cleared immediately on reset assertion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, addresses the ROM, and fills the IF/ID register.
// Handles stall, branch redirect with squash, and sticky fetch-fault detection.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                MEM_SIZE = 1024,
  parameter logic [ADDR_W-1:0] RESET_PC = 64'd0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      stall,
  input  logic                      redirect,
  input  logic [ADDR_W-1:0]         redirect_pc,
  instr_fetch_unit_if.master        imem,
  output logic                      ifid_valid,
  output logic [ADDR_W-1:0]         ifid_pc,
  output logic [INSTR_W-1:0]        ifid_instruction,
  output logic                      fault,
  output logic [31:0]               fetch_count
);

  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_SIZE);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              fault_q, fault_d;
  logic [31:0]       count_q, count_d;
  logic              ifid_load, ifid_squash;
  logic              bad_fetch;

  assign bad_fetch = fetch_is_bad(pc_q, MEM_LIMIT);

  // Next-state decode; redirect outranks stall, which outranks the fault check.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fault_d     = fault_q;
    count_d     = count_q;
    ifid_load   = 1'b0;
    ifid_squash = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (redirect) begin
          pc_d        = redirect_pc;
          ifid_squash = 1'b1;
        end else if (!stall) begin
          if (bad_fetch) begin
            state_d     = ST_FAULT;
            fault_d     = 1'b1;
            ifid_squash = 1'b1;
          end else begin
            ifid_load = 1'b1;
            pc_d      = pc_q + ADDR_W'(INSTR_BYTES);
            count_d   = count_q + 32'd1;
          end
        end
      end
      ST_FAULT: begin
        ifid_squash = 1'b1;
      end
      default: begin
        state_d = ST_FAULT;
        fault_d = 1'b1;
      end
    endcase
  end

  // Fetch FSM, PC, fault flag and delivery counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
      count_q <= count_d;
    end
  end

  ifid_reg u_ifid (
    .clk      (clk),
    .reset_n  (reset_n),
    .load_i   (ifid_load),
    .squash_i (ifid_squash),
    .pc_i     (pc_q),
    .instr_i  (imem.imem_instruction),
    .valid_o  (ifid_valid),
    .pc_o     (ifid_pc),
    .instr_o  (ifid_instruction)
  );

  assign imem.imem_address = pc_q;
  assign fault             = fault_q;
  assign fetch_count       = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural reference model.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam int MEM_SIZE = 1024;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        ifid_valid;
  logic [63:0] ifid_pc;
  logic [31:0] ifid_instruction;
  logic        fault;
  logic [31:0] fetch_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] rom [256];

  instr_fetch_unit_if bus ();

  assign bus.imem_instruction = (bus.imem_address < 64'd1024) ?
                                rom[bus.imem_address[9:2]] : 32'hDEAD_BEEF;

  instr_fetch_unit #(.MEM_SIZE(MEM_SIZE), .RESET_PC(64'd0)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .stall            (stall),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .imem             (bus.master),
    .ifid_valid       (ifid_valid),
    .ifid_pc          (ifid_pc),
    .ifid_instruction (ifid_instruction),
    .fault            (fault),
    .fetch_count      (fetch_count)
  );

  always #5 clk = ~clk;

  // Reference model: what the fetch stage must show, from its rules.
  logic        m_boot = 1'b1;
  logic        m_fault = 1'b0;
  logic [63:0] m_pc = '0;
  logic        m_valid = 1'b0;
  logic [63:0] m_ifpc = '0;
  logic [31:0] m_instr = '0;
  logic [31:0] m_count = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_boot  <= 1'b1;
      m_fault <= 1'b0;
      m_pc    <= 64'd0;
      m_valid <= 1'b0;
      m_ifpc  <= '0;
      m_instr <= '0;
      m_count <= '0;
    end else if (m_boot) begin
      m_boot <= 1'b0;
    end else if (m_fault) begin
      m_valid <= 1'b0;
    end else if (redirect) begin
      m_pc    <= redirect_pc;
      m_valid <= 1'b0;
    end else if (!stall) begin
      if ((m_pc % 4 != 0) || (m_pc > 64'(MEM_SIZE - 4))) begin
        m_fault <= 1'b1;
        m_valid <= 1'b0;
      end else begin
        m_valid <= 1'b1;
        m_ifpc  <= m_pc;
        m_instr <= rom[m_pc[9:2]];
        m_pc    <= m_pc + 64'd4;
        m_count <= m_count + 32'd1;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every falling edge: DUT outputs against the model.
  always @(negedge clk) begin
    chk("m_addr",  bus.imem_address, m_pc);
    chk("m_valid", 64'(ifid_valid), 64'(m_valid));
    chk("m_fault", 64'(fault), 64'(m_fault));
    chk("m_count", 64'(fetch_count), 64'(m_count));
    if (m_valid) begin
      chk("m_ifpc",  ifid_pc, m_ifpc);
      chk("m_instr", 64'(ifid_instruction), 64'(m_instr));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'hA5A5_0000 | 32'(i);

    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    step(1);
    chk("boot_valid", 64'(ifid_valid), 64'd0);
    chk("boot_addr", bus.imem_address, 64'd0);
    step(1);
    chk("first_pc", ifid_pc, 64'd0);
    chk("first_instr", 64'(ifid_instruction), 64'hA5A5_0000);
    step(1);
    chk("second_pc", ifid_pc, 64'd4);

    stall = 1'b1;
    step(3);
    stall = 1'b0;
    chk("stall_addr", bus.imem_address, 64'd8);
    chk("stall_pc", ifid_pc, 64'd4);
    chk("stall_instr", 64'(ifid_instruction), 64'hA5A5_0001);
    chk("stall_count", 64'(fetch_count), 64'd2);
    step(1);
    chk("resume_pc", ifid_pc, 64'd8);
    chk("resume_instr", 64'(ifid_instruction), 64'hA5A5_0002);

    redirect = 1'b1; redirect_pc = 64'h40;
    step(1);
    redirect = 1'b0;
    chk("redir_bubble", 64'(ifid_valid), 64'd0);
    chk("redir_addr", bus.imem_address, 64'h40);
    step(1);
    chk("redir_pc", ifid_pc, 64'h40);
    chk("redir_instr", 64'(ifid_instruction), 64'hA5A5_0010);
    chk("redir_count", 64'(fetch_count), 64'd4);

    redirect = 1'b1; stall = 1'b1; redirect_pc = 64'h100;
    step(1);
    redirect = 1'b0; stall = 1'b0;
    chk("rs_bubble", 64'(ifid_valid), 64'd0);
    chk("rs_addr", bus.imem_address, 64'h100);
    step(1);
    chk("rs_instr", 64'(ifid_instruction), 64'hA5A5_0040);

    redirect = 1'b1; redirect_pc = 64'h3FE;
    step(1);
    redirect = 1'b0;
    chk("mis_nofault", 64'(fault), 64'd0);
    step(1);
    chk("mis_fault", 64'(fault), 64'd1);
    chk("mis_valid", 64'(ifid_valid), 64'd0);
    redirect = 1'b1; stall = 1'b1; redirect_pc = 64'h10;
    step(2);
    redirect = 1'b0; stall = 1'b0;
    chk("sticky_fault", 64'(fault), 64'd1);
    chk("sticky_addr", bus.imem_address, 64'h3FE);

    #2 reset_n = 1'b0;
    #1;
    chk("arst_addr", bus.imem_address, 64'd0);
    chk("arst_fault", 64'(fault), 64'd0);
    chk("arst_count", 64'(fetch_count), 64'd0);
    chk("arst_valid", 64'(ifid_valid), 64'd0);
    step(1);
    reset_n = 1'b1;
    step(2);
    chk("rerun_instr", 64'(ifid_instruction), 64'hA5A5_0000);

    redirect = 1'b1; redirect_pc = 64'h3FC;
    step(1);
    redirect = 1'b0;
    step(1);
    chk("top_pc", ifid_pc, 64'h3FC);
    chk("top_instr", 64'(ifid_instruction), 64'hA5A5_00FF);
    chk("top_nofault", 64'(fault), 64'd0);
    step(1);
    chk("over_fault", 64'(fault), 64'd1);
    chk("over_addr", bus.imem_address, 64'h400);

    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    step(1);
    redirect = 1'b1; redirect_pc = 64'h3FE;
    step(1);
    redirect_pc = 64'h20;
    step(1);
    redirect = 1'b0;
    chk("redir_beats_fault", 64'(fault), 64'd0);
    chk("redir_beats_addr", bus.imem_address, 64'h20);
    step(1);
    chk("after_beat_instr", 64'(ifid_instruction), 64'hA5A5_0008);

    redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    step(1);
    redirect = 1'b0;
    step(1);
    chk("wrap_fault", 64'(fault), 64'd1);
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
